rr_merge_arbiter: RTL and testbench
===================================

# rr_merge_arbiter

Two-input round-robin arbiter that shares one registered output channel between two packet streams, producing the per-beat select that drives the 2:1 output mux. Packets are multi-beat (terminated by `last`); once a requester wins, it holds the channel until its last beat is accepted, so packets never interleave. The block sits upstream of a single shared consumer and owns both the select state and the output pipeline register.

## Interface
Parameters:
- WIDTH, 8, data bits per beat

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in0_valid  in  1  requester 0 beat valid
- in0_data  in  WIDTH  requester 0 beat data
- in0_last  in  1  requester 0 final beat of packet
- in0_ready  out  1  requester 0 beat accepted this cycle (when in0_valid)
- in1_valid / in1_data / in1_last / in1_ready  same as requester 0, for requester 1
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered beat data
- out_last  out  1  registered last flag
- out_src  out  1  source index (0/1) of registered beat
- out_ready  in  1  consumer accepts output beat
- busy  out  1  high while state is LOCK0 or LOCK1

## Operation
- State: `state` ∈ {IDLE, LOCK0, LOCK1}; `prio` (1 bit, requester that wins a tie in IDLE).
- Output register free when `!out_valid | out_ready` (`can_load`).
- Winner select (combinational):
  - IDLE: only one valid → that one; both valid → `prio`; none → no winner.
  - LOCKx: winner is x only, regardless of the other requester's valid; the other sees ready=0.
- `inx_ready = can_load & (x is winner) & !rst`. Beat accepted when `inx_valid & inx_ready`.
- On accept from x: output register loads {data, last, src=x}, out_valid=1.
  - last=0: state → LOCKx (or stays LOCKx).
  - last=1: state → IDLE, `prio` ← ~x.
- No accept and `out_ready`: out_valid → 0; data/last/src hold their last values.
- In LOCKx, gaps in inx_valid keep the lock; the other requester waits indefinitely (no timeout).
- Single-beat packet (last=1 on first beat) never enters LOCK; still flips `prio`.
- Arithmetic: none beyond 1-bit flip of `prio`; no counters overflow.

## Timing
- Reset values: state=IDLE, prio=0, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, in0_ready=in1_ready=0.
- Reset asserted mid-packet: lock dropped, registered beat discarded (out_valid=0) immediately; requesters must restart packets.
- Latency: beat accepted at edge N appears on out_* after edge N (visible cycle N+1).
- Throughput: 1 beat/cycle with out_ready held high, including back-to-back packets from alternating requesters (no bubble on IDLE re-arbitration).
- Back-pressure: out_ready=0 with out_valid=1 → both in*_ready=0, out_* stable until accepted.
- Simultaneous out_ready=1 and new accept in same cycle: register replaces contents, out_valid stays 1.
- in*_ready is combinational from out_valid, out_ready, state, prio, in*_valid; no combinational path from in*_data.
- busy reflects registered state (LOCK0/LOCK1), updates one edge after the non-last beat is accepted.

## Test plan
- Reset then idle: all outputs 0; assert rst asynchronously mid-cycle with out_valid=1 → out_valid drops before next edge.
- Tie from reset: in0 and in1 each present one single-beat packet (0x11, 0x22) simultaneously, out_ready=1 → out sequence 0x11 (src 0) then 0x22 (src 1), cycle after each accept, no bubble.
- Lock hold: in0 sends 3-beat packet 0xA0,0xA1,0xA2 with a 2-cycle valid gap after 0xA0 while in1 valid with 0xB0 → in1_ready stays 0 until 0xA2 accepted; output 0xA0,0xA1,0xA2,0xB0; busy high from cycle after 0xA0 through 0xA2 accept.
- Fairness: both requesters stream single-beat packets continuously for 8 cycles → out_src alternates 0,1,0,1,…; with only in1 active, in1 wins every cycle.
- Back-pressure: out_ready=0 for 4 cycles with out_valid=1, data 0x5C → out_data stays 0x5C, both ready=0; release → 0x5C consumed, next beat follows on the next cycle.
- Reset mid-packet: in1 in LOCK1 after beat 0x30, assert rst → state IDLE, prio=0; after release, in0 and in1 tie → in0 wins.

Source files
------------

// File: rtl/rr_merge_arbiter.sv
// Two-input round-robin packet arbiter feeding one registered output channel.
// A winner keeps the channel until its last beat is accepted, so packets never interleave.
module rr_merge_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic             dbg_prio
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state, state_next;
    logic   prio, prio_next;
    logic   can_load;
    logic   grant0, grant1;
    logic   acc0, acc1, accept, acc_last;

    // Handshake: a beat transfers on any edge where valid & ready are both high;
    // ready never depends on data, and a producer holds valid/data until it transfers.
    assign can_load  = !out_valid | out_ready;
    assign in0_ready = can_load & grant0 & !rst;
    assign in1_ready = can_load & grant1 & !rst;
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;
    assign accept    = acc0 | acc1;
    assign acc_last  = acc1 ? in1_last : in0_last;

    assign busy      = (state == LOCK0) || (state == LOCK1);
    assign dbg_state = state;
    assign dbg_prio  = prio;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        prio_next  = prio;
        case (state)
            IDLE: begin
                grant0 = in0_valid & (!in1_valid | !prio);
                grant1 = in1_valid & (!in0_valid | prio);
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            if (acc_last) begin
                state_next = IDLE;
                prio_next  = ~acc1;
            end else begin
                state_next = acc1 ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= acc1 ? in1_data : in0_data;
                out_last  <= acc_last;
                out_src   <= acc1;
            end else if (out_ready) begin
                // Payload fields keep their last values once the beat is consumed.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Directed bench for rr_merge_arbiter: reset, ties, lock hold, fairness,
// back-pressure and reset mid-packet, checked with immediate assertions.
module tb_rr_merge_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid, in0_last, in0_ready;
    logic [7:0] in0_data;
    logic       in1_valid, in1_last, in1_ready;
    logic [7:0] in1_data;
    logic       out_valid, out_last, out_src, out_ready, busy, dbg_prio;
    logic [7:0] out_data;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_merge_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state), .dbg_prio(dbg_prio)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] data, input logic last, input logic src);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(data));
        chk({tag, "_last"}, 32'(out_last), 32'(last));
        chk({tag, "_src"}, 32'(out_src), 32'(src));
    endtask

    initial begin
        rst = 1'b1;
        in0_valid = 1'b0; in0_data = 8'h00; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b0;
        out_ready = 1'b0;

        // Reset values, with requests present while reset is held
        step(); step();
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_prio", 32'(dbg_prio), 32'd0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset drops a held beat before the next edge
        in0_valid = 1'b1; in0_data = 8'h33; in0_last = 1'b1;
        step();
        in0_valid = 1'b0;
        chk_out("async_pre", 8'h33, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_prio", 32'(dbg_prio), 32'd0);
        step();
        rst = 1'b0;

        // Tie from reset: in0 first, then in1 with no bubble
        in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("tie_in0_ready", 32'(in0_ready), 32'd1);
        chk("tie_in1_ready", 32'(in1_ready), 32'd0);
        step();
        in0_valid = 1'b0;
        #1;
        chk_out("tie_b0", 8'h11, 1'b1, 1'b0);
        chk("tie_in1_ready2", 32'(in1_ready), 32'd1);
        step();
        in1_valid = 1'b0;
        chk_out("tie_b1", 8'h22, 1'b1, 1'b1);
        step();
        chk("tie_drain", 32'(out_valid), 32'd0);

        // Lock hold: in0 keeps the channel through a 2-cycle gap
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        #1;
        chk("lock_in0_ready", 32'(in0_ready), 32'd1);
        chk("lock_in1_ready0", 32'(in1_ready), 32'd0);
        step();
        in0_valid = 1'b0;
        #1;
        chk_out("lock_a0", 8'hA0, 1'b0, 1'b0);
        chk("lock_busy0", 32'(busy), 32'd1);
        chk("lock_in1_ready1", 32'(in1_ready), 32'd0);
        step();
        chk("lock_gap_valid", 32'(out_valid), 32'd0);
        chk("lock_gap_busy", 32'(busy), 32'd1);
        chk("lock_in1_ready2", 32'(in1_ready), 32'd0);
        step();
        chk("lock_in1_ready3", 32'(in1_ready), 32'd0);
        in0_valid = 1'b1; in0_data = 8'hA1; in0_last = 1'b0;
        step();
        in0_data = 8'hA2; in0_last = 1'b1;
        #1;
        chk_out("lock_a1", 8'hA1, 1'b0, 1'b0);
        chk("lock_busy_a2", 32'(busy), 32'd1);
        chk("lock_in1_ready4", 32'(in1_ready), 32'd0);
        step();
        in0_valid = 1'b0;
        #1;
        chk_out("lock_a2", 8'hA2, 1'b1, 1'b0);
        chk("lock_busy_end", 32'(busy), 32'd0);
        chk("lock_in1_ready5", 32'(in1_ready), 32'd1);
        step();
        in1_valid = 1'b0;
        chk_out("lock_b0", 8'hB0, 1'b1, 1'b1);
        step();
        chk("lock_drain", 32'(out_valid), 32'd0);

        // Fairness: both stream single-beat packets, src alternates from 0
        in0_valid = 1'b1; in0_data = 8'h40; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h50; in1_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("fair_%0d", i), (i % 2 == 1) ? 8'h50 : 8'h40, 1'b1, 1'((i % 2)));
        end
        in0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("solo1_%0d", i), 8'h50, 1'b1, 1'b1);
        end
        in1_valid = 1'b0;
        step();
        chk("fair_drain", 32'(out_valid), 32'd0);

        // Back-pressure: 0x5C held four cycles, then in1 (prio) and in0 follow
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h5C; in0_last = 1'b1;
        step();
        in0_data = 8'h5D;
        in1_valid = 1'b1; in1_data = 8'h6E; in1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_out($sformatf("bp_hold_%0d", i), 8'h5C, 1'b1, 1'b0);
            chk($sformatf("bp_in0_ready_%0d", i), 32'(in0_ready), 32'd0);
            chk($sformatf("bp_in1_ready_%0d", i), 32'(in1_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_in1_ready", 32'(in1_ready), 32'd1);
        chk("bp_rel_in0_ready", 32'(in0_ready), 32'd0);
        step();
        in1_valid = 1'b0;
        chk_out("bp_next", 8'h6E, 1'b1, 1'b1);
        step();
        in0_valid = 1'b0;
        chk_out("bp_next2", 8'h5D, 1'b1, 1'b0);
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Reset mid-packet in LOCK1 while prio is 1, then in0 wins the tie
        in1_valid = 1'b1; in1_data = 8'h30; in1_last = 1'b0;
        step();
        in1_data = 8'h31;
        in0_valid = 1'b1; in0_data = 8'h70; in0_last = 1'b1;
        #1;
        chk_out("mid_b30", 8'h30, 1'b0, 1'b1);
        chk("mid_state", 32'(dbg_state), 32'd2);
        chk("mid_prio_pre", 32'(dbg_prio), 32'd1);
        chk("mid_in0_ready", 32'(in0_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        chk("mid_rst_prio", 32'(dbg_prio), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        in1_data = 8'h30; in1_last = 1'b1;
        #1;
        chk("mid_tie_in0_ready", 32'(in0_ready), 32'd1);
        chk("mid_tie_in1_ready", 32'(in1_ready), 32'd0);
        step();
        in0_valid = 1'b0; in1_valid = 1'b0;
        chk_out("mid_tie", 8'h70, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
